// File: rtl/instruction_memory.sv
// Purpose: splits a MIPS instruction word into its bit-fields and holds a classified copy in a decode register.
// Latency: the IS_* field outputs have zero latency; the q_* decode register has 1 cycle from in_valid.
// Backpressure: none; a new word can load on every in_valid cycle without stalling.
//
// Ports:
//   clk, rst_n     - rising-edge clock, asynchronous active-low reset
//   IS             - instruction word from fetch
//   IS_*           - raw opcode/rs/rt/immediate/funct fields, always live (not gated by reset or in_valid)
//   in_valid       - load the decode register this cycle
//   q_*            - registered word, extended immediates, jump target and opcode class
module instruction_memory #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] IS,
  output logic [5:0]        IS_5_0,
  output logic [15:0]       IS_15_0,
  output logic [4:0]        IS_20_16,
  output logic [4:0]        IS_25_21,
  output logic [5:0]        IS_31_26,
  input  logic              in_valid,
  output logic              q_valid,
  output logic [31:0]       q_instr,
  output logic [4:0]        q_rd,
  output logic [4:0]        q_shamt,
  output logic [31:0]       q_imm_sext,
  output logic [31:0]       q_imm_zext,
  output logic [25:0]       q_jtarget,
  output logic              q_rtype,
  output logic              q_jtype,
  output logic              q_itype,
  output logic              q_illegal
);

  // Raw field taps: plain wires so X/Z on IS pass straight through.
  assign IS_5_0   = IS[5:0];
  assign IS_15_0  = IS[15:0];
  assign IS_20_16 = IS[20:16];
  assign IS_25_21 = IS[25:21];
  assign IS_31_26 = IS[31:26];

  logic [5:0] opcode;
  logic       is_rtype;
  logic       is_jtype;
  logic       is_legal;

  assign opcode   = IS[31:26];
  assign is_rtype = (opcode == 6'h00);
  assign is_jtype = (opcode == 6'h02) || (opcode == 6'h03);

  always_comb begin
    is_legal = 1'b0;
    case (opcode)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
      6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B: is_legal = 1'b1;
      default:                                  is_legal = 1'b0;
    endcase
  end

  // Class bits are registered explicitly (not re-derived from q_instr) so that
  // reset can force every class flag to 0 rather than reading as R-type.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid    <= 1'b0;
      q_instr    <= '0;
      q_rd       <= '0;
      q_shamt    <= '0;
      q_imm_sext <= '0;
      q_imm_zext <= '0;
      q_jtarget  <= '0;
      q_rtype    <= 1'b0;
      q_jtype    <= 1'b0;
      q_itype    <= 1'b0;
      q_illegal  <= 1'b0;
    end else begin
      q_valid <= in_valid;
      // Without in_valid only q_valid drops; the payload keeps its last value.
      if (in_valid) begin
        q_instr    <= IS[31:0];
        q_rd       <= IS[15:11];
        q_shamt    <= IS[10:6];
        q_imm_sext <= {{16{IS[15]}}, IS[15:0]};
        q_imm_zext <= {16'h0000, IS[15:0]};
        q_jtarget  <= IS[25:0];
        q_rtype    <= is_rtype;
        q_jtype    <= is_jtype;
        q_itype    <= !is_rtype && !is_jtype;
        q_illegal  <= !is_legal;
      end
    end
  end

endmodule

// File: tb/tb_instruction_memory.sv
module tb_instruction_memory;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] IS;
  logic        in_valid;
  logic [5:0]  IS_5_0;
  logic [15:0] IS_15_0;
  logic [4:0]  IS_20_16;
  logic [4:0]  IS_25_21;
  logic [5:0]  IS_31_26;
  logic        q_valid;
  logic [31:0] q_instr;
  logic [4:0]  q_rd;
  logic [4:0]  q_shamt;
  logic [31:0] q_imm_sext;
  logic [31:0] q_imm_zext;
  logic [25:0] q_jtarget;
  logic        q_rtype;
  logic        q_jtype;
  logic        q_itype;
  logic        q_illegal;

  always #5 clk = ~clk;

  instruction_memory #(.DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .IS         (IS),
    .IS_5_0     (IS_5_0),
    .IS_15_0    (IS_15_0),
    .IS_20_16   (IS_20_16),
    .IS_25_21   (IS_25_21),
    .IS_31_26   (IS_31_26),
    .in_valid   (in_valid),
    .q_valid    (q_valid),
    .q_instr    (q_instr),
    .q_rd       (q_rd),
    .q_shamt    (q_shamt),
    .q_imm_sext (q_imm_sext),
    .q_imm_zext (q_imm_zext),
    .q_jtarget  (q_jtarget),
    .q_rtype    (q_rtype),
    .q_jtype    (q_jtype),
    .q_itype    (q_itype),
    .q_illegal  (q_illegal)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [31:0] sext;
    logic [31:0] zext;
    logic [25:0] jt;
    logic        rtype;
    logic        jtype;
    logic        itype;
    logic        illegal;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int   checks   = 0;
  int   failures = 0;

  logic [5:0] legal_ops [13] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
                                 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    logic [5:0] op;
    op        = w[31:26];
    e.instr   = w;
    e.rd      = w[15:11];
    e.shamt   = w[10:6];
    e.sext    = {{16{w[15]}}, w[15:0]};
    e.zext    = {16'h0000, w[15:0]};
    e.jt      = w[25:0];
    e.rtype   = (op == 6'h00);
    e.jtype   = (op == 6'h02) || (op == 6'h03);
    e.itype   = !e.rtype && !e.jtype;
    e.illegal = 1'b1;
    foreach (legal_ops[i]) if (legal_ops[i] == op) e.illegal = 1'b0;
    return e;
  endfunction

  task automatic check_q(input exp_t e, input logic v);
    check("q_valid",    32'(q_valid),    32'(v));
    check("q_instr",    q_instr,         e.instr);
    check("q_rd",       32'(q_rd),       32'(e.rd));
    check("q_shamt",    32'(q_shamt),    32'(e.shamt));
    check("q_imm_sext", q_imm_sext,      e.sext);
    check("q_imm_zext", q_imm_zext,      e.zext);
    check("q_jtarget",  32'(q_jtarget),  32'(e.jt));
    check("q_rtype",    32'(q_rtype),    32'(e.rtype));
    check("q_jtype",    32'(q_jtype),    32'(e.jtype));
    check("q_itype",    32'(q_itype),    32'(e.itype));
    check("q_illegal",  32'(q_illegal),  32'(e.illegal));
  endtask

  task automatic check_zero();
    exp_t z;
    z = '0;
    check_q(z, 1'b0);
  endtask

  // Drive one word, advance one edge, then compare against the scoreboard.
  task automatic cycle(input logic [31:0] w, input logic v);
    IS       = w;
    in_valid = v;
    if (v && rst_n) sb.push_back(model(w));
    @(posedge clk);
    #1;
    if (!rst_n) begin
      check_zero();
    end else if (sb.size() > 0) begin
      last_exp = sb.pop_front();
      check_q(last_exp, 1'b1);
    end else begin
      check_q(last_exp, 1'b0);
    end
  endtask

  initial begin
    last_exp = '0;
    IS       = 32'h0;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check_zero();

    // Field taps, no clocking involved.
    IS = 32'h20000000;
    #1;
    check("f0_imm",    32'(IS_15_0),  32'h0000);
    check("f0_funct",  32'(IS_5_0),   32'h00);
    check("f0_rt",     32'(IS_20_16), 32'h00);
    check("f0_rs",     32'(IS_25_21), 32'h00);
    check("f0_opcode", 32'(IS_31_26), 32'h08);
    for (int i = 1; i <= 3; i++) begin
      IS = 32'h20000000 | (32'(i) << 21) | (32'(i) << 16) | 32'(i);
      #1;
      check("fs_imm",    32'(IS_15_0),  32'(i));
      check("fs_rt",     32'(IS_20_16), 32'(i));
      check("fs_rs",     32'(IS_25_21), 32'(i));
      check("fs_funct",  32'(IS_5_0),   32'(i));
      check("fs_opcode", 32'(IS_31_26), 32'h08);
    end
    IS = 'x;
    #1;
    check("x_prop_imm", 32'(IS_15_0), 32'h0000xxxx);

    // In reset with in_valid and clock running: register stays clear, taps track IS.
    for (int i = 0; i < 3; i++) begin
      cycle(32'h10A5_0000 + 32'(i), 1'b1);
      check("rst_tap_op",  32'(IS_31_26), 32'h04);
      check("rst_tap_imm", 32'(IS_15_0),  32'(i));
    end
    rst_n = 1'b1;

    cycle(32'h2021FFFF, 1'b1);
    check("sext_ffff", q_imm_sext,      32'hFFFFFFFF);
    check("zext_ffff", q_imm_zext,      32'h0000FFFF);
    check("itype_addi", 32'(q_itype),   32'h1);

    cycle(32'h00221820, 1'b1);
    check("add_rd",    32'(q_rd),       32'h3);
    check("add_rtype", 32'(q_rtype),    32'h1);
    cycle(32'h08000010, 1'b1);
    check("j_jtype",   32'(q_jtype),    32'h1);
    check("j_target",  32'(q_jtarget),  32'h0000010);

    cycle(32'hFC000000, 1'b1);
    check("ill_flag",  32'(q_illegal),  32'h1);
    check("ill_itype", 32'(q_itype),    32'h1);
    cycle(32'h12345678, 1'b0);
    check("hold_instr", q_instr,        32'hFC000000);
    check("hold_valid", 32'(q_valid),   32'h0);

    // Every supported opcode, back to back.
    foreach (legal_ops[i]) cycle({legal_ops[i], 26'h2A5_5A5A}, 1'b1);

    // Random words with random valid gaps.
    for (int i = 0; i < 40; i++) cycle($urandom, 1'($urandom_range(0, 1)));

    // Mid-stream asynchronous reset between edges.
    cycle(32'h8C410004, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_zero();
    last_exp = '0;
    cycle(32'h8C410008, 1'b1);
    rst_n = 1'b1;
    cycle(32'h3C01ABCD, 1'b1);
    check("post_rst_instr", q_instr, 32'h3C01ABCD);
    cycle(32'h0, 1'b0);

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
